axi4lite_csr_regs: RTL



---
 rtl/axi4lite_csr_regs_if.sv | 31 +++
 rtl/axi4lite_csr_regs.sv | 108 ++++++++++
 2 files changed

// File: rtl/axi4lite_csr_regs_if.sv
// axi4lite_if: 32-bit AXI4-Lite bus bundle with master and slave modports
interface axi4lite_if #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32
);
  logic [ADDRW-1:0]   awaddr;
  logic               awvalid;
  logic               awready;
  logic [DATAW-1:0]   wdata;
  logic [DATAW/8-1:0] wstrb;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [ADDRW-1:0]   araddr;
  logic               arvalid;
  logic               arready;
  logic [DATAW-1:0]   rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_csr_regs.sv
// axi4lite_csr_regs: AXI4-Lite CSR bank for MIG control/status/irq; SCRATCH at 0x08 exists only with CSR_SCRATCH_EN
module axi4lite_csr_regs #(
  parameter int          NSTAT    = 8,
  parameter logic [31:0] CTRL_RST = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE = 32'h4D49_4701
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi4lite_if.slave        s,
  output logic [31:0]      ctrl_out,
  input  logic [NSTAT-1:0] status_in,
  output logic             irq
);
`ifdef CSR_SCRATCH_EN
  localparam logic HAS_SCR = 1'b1;
`else
  localparam logic HAS_SCR = 1'b0;
`endif
  logic             awready_q, awready_d, bvalid_q, bvalid_d;
  logic             arready_q, arready_d, rvalid_q, rvalid_d;
  logic             irq_q, irq_d;
  logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]      rdata_q, rdata_d, ctrl_q, ctrl_d, scratch_q, scratch_d;
  logic [NSTAT-1:0] irq_stat_q, irq_stat_d, irq_en_q, irq_en_d;
  logic [NSTAT-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [5:0]       widx, ridx;
  logic             we, re, w_map, r_map;
  logic [31:0]      mask, wval, rval;
  logic             unused_ok;
  assign widx = s.awaddr[7:2];
  assign ridx = s.araddr[7:2];
  assign we   = awready_q && s.awvalid && s.wvalid;
  assign re   = arready_q && s.arvalid;
  assign mask = {{8{s.wstrb[3]}}, {8{s.wstrb[2]}}, {8{s.wstrb[1]}}, {8{s.wstrb[0]}}};
  assign wval = s.wdata & mask;
  assign unused_ok = ^{s.awaddr[31:8], s.awaddr[1:0], s.araddr[31:8], s.araddr[1:0]};
  always_comb begin
    w_map = (widx <= 6'd5) && (HAS_SCR || widx != 6'd2);
    r_map = (ridx <= 6'd5) && (HAS_SCR || ridx != 6'd2);
    rval = ridx == 6'd0 ? ctrl_q :
           ridx == 6'd1 ? 32'(sync2_q) :
           ridx == 6'd2 ? scratch_q :
           ridx == 6'd3 ? 32'(irq_stat_q) :
           ridx == 6'd4 ? 32'(irq_en_q) :
           ridx == 6'd5 ? ID_VALUE : 32'h0;
    awready_d = s.awvalid && s.wvalid && !bvalid_q && !awready_q;
    bvalid_d  = we || (bvalid_q && !s.bready);
    bresp_d   = we ? (w_map ? 2'b00 : 2'b10) : bresp_q;
    arready_d = s.arvalid && !rvalid_q && !arready_q;
    rvalid_d  = re || (rvalid_q && !s.rready);
    rdata_d   = re ? (r_map ? rval : 32'h0) : rdata_q;
    rresp_d   = re ? (r_map ? 2'b00 : 2'b10) : rresp_q;
    ctrl_d    = (we && widx == 6'd0) ? ((ctrl_q & ~mask) | wval) : ctrl_q;
    scratch_d = (HAS_SCR && we && widx == 6'd2) ? ((scratch_q & ~mask) | wval) : scratch_q;
    irq_en_d  = (we && widx == 6'd4) ? ((irq_en_q & ~mask[NSTAT-1:0]) | wval[NSTAT-1:0]) : irq_en_q;
    // a fresh synced rising edge outranks a same-cycle W1C clear
    irq_stat_d = (irq_stat_q & ~({NSTAT{we && widx == 6'd3}} & wval[NSTAT-1:0])) | (sync2_q & ~sync3_q);
    irq_d   = |(irq_stat_q & irq_en_q);
    sync1_d = status_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= 2'b00;
      ctrl_q     <= CTRL_RST;
      scratch_q  <= 32'h0;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
    end else begin
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      ctrl_q     <= ctrl_d;
      scratch_q  <= scratch_d;
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
    end
  end
  assign s.awready = awready_q;
  assign s.wready  = awready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign ctrl_out  = ctrl_q;
  assign irq       = irq_q;
endmodule
